counter_event_logger: RTL
=========================

Name: counter_event_logger

Overview:
- Downstream consumer of the periodic counter host's outputs: `count_out`, `overflow` and `pulse_out`.
- On every rising edge of the host pulse, captures a timestamp snapshot of the count. Each snapshot is tagged with whether an overflow occurred since the previous snapshot.
- Snapshots are buffered in a small FIFO and drained over a valid/ready interface towards the readout/host-interface logic.
- Events are counted as drops when the FIFO is full.

Parameters:
- WIDTH, 12, width of the captured count (matches host `count_out`).
- DEPTH, 4, FIFO entries; power of two, at least 2.
- DROP_W, 8, width of the saturating dropped-event counter.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high; all state cleared immediately on assertion.
- count_in  input  WIDTH  host `count_out`.
- overflow_in  input  1  host `overflow`.
- pulse_in  input  1  host `pulse_out`.
- clear  input  1  synchronous flush of FIFO, drop counter and overflow sticky bit.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head entry.
- out_data  output  WIDTH+1  {ovf_tag, count}, head entry.
- fifo_level  output  clog2(DEPTH)+1  number of stored entries (0..DEPTH).
- drop_count  output  DROP_W  events lost due to full FIFO, saturating.

Behaviour:
- Reset values: out_valid=0, out_data=0, fifo_level=0, drop_count=0. Internal pulse_d=0, ovf_sticky=0, and all pointers 0.
- Edge detect:
  - pulse_d <= pulse_in every cycle, including during clear.
  - event = pulse_in & ~pulse_d.
  - A pulse held high for N cycles produces one event.
  - A pulse_in already high in the first cycle after reset release counts as an event.
- Capture values:
  - Count is the value of count_in in the event cycle.
  - ovf_tag = ovf_sticky | overflow_in in the same cycle.
- Overflow sticky:
  - ovf_sticky is set by overflow_in=1.
  - On an event cycle it is cleared to 0, regardless of whether the entry was written or dropped.
  - Exception: if overflow_in=1 in the event cycle, that overflow belongs to the captured entry, and sticky still goes to 0.
- Pop: pop = out_valid & out_ready.
- Push:
  - push = event & (fifo_level<DEPTH | pop).
  - A push while full is legal only with a simultaneous pop; level stays DEPTH.
- Drop:
  - If event is high and push is low, drop_count increments.
  - drop_count holds at 2^DROP_W-1.
- Latency:
  - Event in cycle N gives an entry visible at out_data, with out_valid=1, in cycle N+1 when the FIFO was empty.
  - No combinational path from pulse_in/count_in to out_*.
- out_data:
  - out_data presents the head entry directly from storage and is stable while out_valid=1 and out_ready=0.
  - When empty, out_data holds its last value; it is 0 after reset.
- Simultaneous push+pop when non-empty: level unchanged, order preserved (strict FIFO).
- Pointers wrap modulo DEPTH.
- Clear:
  - clear=1 has priority over push, pop and drop in the same cycle.
  - Next cycle: level=0, out_valid=0, drop_count=0, ovf_sticky=0.
  - An event in the clear cycle is discarded and not counted.
- Reset asserted mid-operation: all stored entries are lost and outputs go to reset values asynchronously. Operation resumes on the first clk edge after deassertion.

Decomposition:
- Shared package contents:
  - Constant CNT_W=12, shared with the counter host.
  - Typedef event_entry_t {logic ovf_tag; logic [CNT_W-1:0] count}.
  - Function computing the level width.
- One sub-module, event_fifo:
  - Parameterised DEPTH and entry type.
  - Provides push/pop/level/full/empty and head data.
  - Contains the asynchronous-reset storage pointers.
- Edge detect, sticky bit, drop counter and clear priority stay in the top module.

Test Plan:
- Reset, then pulse_in high for 3 cycles with count_in=0x123, then out_ready=1 -> exactly one entry, out_data=0x0123 (tag 0), out_valid one cycle after the edge, level returns to 0.
- overflow_in pulsed at count 0xFFF, then event at count_in=0x005 -> out_data=0x1005; the next event at 0x010 gives out_data=0x0010 (sticky cleared).
- out_ready=0, 6 events with counts 1..6 -> level=4, drop_count=2; then drain -> entries 1,2,3,4 in order.
- FIFO full while an event and out_ready=1 occur in the same cycle -> pop of head and push of new entry, level stays 4, drop_count unchanged.
- drop_count forced past 255 with DROP_W=8 (300 drops) -> reads 255.
- clear asserted with 3 entries and a simultaneous event -> next cycle level=0, out_valid=0, drop_count=0, event not stored. Reset asserted mid-drain -> outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/counter_event_logger_pkg.sv
// Shared types and constants for the counter event logger and the counter host it listens to.
package counter_event_logger_pkg;

    localparam int CNT_W = 12;

    typedef struct packed {
        logic             ovf_tag;
        logic [CNT_W-1:0] count;
    } event_entry_t;

    // Level counter must represent 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/counter_event_logger_event_fifo.sv
// Small strict-order FIFO for captured events; head is read straight from storage.
module event_fifo
    import counter_event_logger_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = event_entry_t,
    localparam int LW      = level_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  entry_t        wdata,
    output entry_t        rdata,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    entry_t          hold_q;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level_q;
    logic            do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign do_pop  = pop & ~empty & ~clear;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop) & ~clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            hold_q  <= '0;
        end else if (clear) begin
            if (!empty) hold_q <= mem[rd_ptr];
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                hold_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Once drained, keep showing the last head rather than a stale slot.
    assign rdata = empty ? hold_q : mem[rd_ptr];
    assign level = level_q;

endmodule

// File: rtl/counter_event_logger.sv
// Timestamps rising edges of the host pulse, tags them with pending overflow and queues them for readout.
module counter_event_logger
    import counter_event_logger_pkg::*;
#(
    parameter int WIDTH  = CNT_W,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          count_in,
    input  logic                      overflow_in,
    input  logic                      pulse_in,
    input  logic                      clear,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH:0]            out_data,
    output logic [level_w(DEPTH)-1:0] fifo_level,
    output logic [DROP_W-1:0]         drop_count
);

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic         pulse_d;
    logic         ovf_sticky;
    logic         evt, push, pop, full, empty;
    event_entry_t wentry, head;

    assign evt = pulse_in & ~pulse_d;
    assign pop = ~empty & out_ready;
    assign push = evt & (~full | pop);

    assign wentry.ovf_tag = ovf_sticky | overflow_in;
    assign wentry.count   = count_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pulse_d <= 1'b0;
        else     pulse_d <= pulse_in;
    end

    // Every event consumes the pending overflow, whether it was stored or dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              ovf_sticky <= 1'b0;
        else if (clear)       ovf_sticky <= 1'b0;
        else if (evt)         ovf_sticky <= 1'b0;
        else if (overflow_in) ovf_sticky <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_count <= '0;
        else if (clear)
            drop_count <= '0;
        else if (evt && !push && drop_count != DROP_MAX)
            drop_count <= drop_count + DROP_W'(1);
    end

    event_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (event_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = ~empty;
    assign out_data  = head;

endmodule
